// File: rtl/square_fsm.sv
// ---------------------------------------------------------------------------
// square_fsm
//
// Sequential unsigned integer squarer: dt_o = dt_i * dt_i.
// A radix-2 shift-add multiplier runs under a three-state FSM (IDLE/CALC/DONE).
// Each operation takes one iteration per operand bit.
// This block is the counterpart of the sqrt block and uses the same
// enb_i/busy_o control handshake, so the two can be swapped or chained.
//
// Ports
//   clk     in   1          system clock, rising edge
//   rstn_i  in   1          asynchronous active-low reset
//   enb_i   in   1          start request, only looked at while idle
//   dt_i    in   WIDTH      operand, captured on the accepted start edge
//   busy_o  out  1          high while an operation is in flight
//   done_o  out  1          one-cycle pulse when dt_o has just been updated
//   dt_o    out  2*WIDTH    result register, holds until the next completion
//
// Timing (start edge E0)
//   busy_o is high from E0 through E(WIDTH+1), which is WIDTH+1 cycles.
//   dt_o and done_o update at E(WIDTH+1).
//   A start request in the done_o cycle is accepted, because the FSM is
//   already back in IDLE by then. Back-to-back operations therefore complete
//   once every WIDTH+2 cycles.
// ---------------------------------------------------------------------------
module square_fsm #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn_i,
  input  logic                 enb_i,
  input  logic [WIDTH-1:0]     dt_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   dt_o
);

  // The counter must be able to hold WIDTH-1, which is the index of the
  // last iteration.
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q,  state_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [2*WIDTH-1:0]   res_q,    res_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;

  // State and datapath registers.
  // Reset discards any in-flight operation. Clearing done_q here also
  // guarantees that an aborted operation never produces a completion pulse.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update logic.
  // Every register holds its value unless the current state says otherwise.
  // done_d defaults low, so done_o is a single-cycle pulse.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Requests are only sampled here, so enb_i is ignored while busy
        // and is never queued.
        if (enb_i) begin
          mcand_d  = {{WIDTH{1'b0}}, dt_i};
          mplier_d = dt_i;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end

      CALC: begin
        // Each iteration consumes one multiplier bit, starting from the LSB.
        // The product of two WIDTH-bit values always fits in 2*WIDTH bits,
        // so the accumulator add can never carry out.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end

      DONE: begin
        res_d   = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Output logic.
  // All outputs come straight from registers, so none of them can glitch.
  always_comb begin
    busy_o = busy_q;
    done_o = done_q;
    dt_o   = res_q;
  end

endmodule

// File: tb/tb_square_fsm.sv
// Testbench for square_fsm (WIDTH = 8).
// Each accepted start pushes its expected square into a queue. A monitor
// pops the queue and compares the entry against dt_o on every done_o pulse.
module tb_square_fsm;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rstn_i;
  logic               enb_i;
  logic [WIDTH-1:0]   dt_i;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] dt_o;

  int testCount  = 0;
  int failCount  = 0;
  int startCount = 0;
  int doneCount  = 0;
  int cycleCount = 0;
  logic prevDone = 1'b0;
  logic [2*WIDTH-1:0] scoreboard[$];

  square_fsm #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rstn_i (rstn_i),
    .enb_i  (enb_i),
    .dt_i   (dt_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .dt_o   (dt_o)
  );

  // Clock generation and a free-running cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Hard time limit, so the bench can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  // Every comparison goes through this task.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Scoreboard monitor. It samples on the falling edge, away from the
  // active clock edge.
  always @(negedge clk) begin
    if (done_o) begin
      doneCount++;
      checkOutput("done_single_cycle", 32'(prevDone), 32'd0);
      if (scoreboard.size() == 0) begin
        checkOutput("spurious_done", 32'd1, 32'd0);
      end else begin
        checkOutput("dt_o", 32'(dt_o), 32'(scoreboard.pop_front()));
      end
    end
    prevDone = done_o;
  end

  // Called at a falling edge while the DUT is idle.
  // Requests a start with the given operand and releases enb_i one cycle
  // later. It then scrambles dt_i, which must have no effect on the result.
  task automatic applyStimulus(input logic [WIDTH-1:0] val);
    dt_i  = val;
    enb_i = 1'b1;
    scoreboard.push_back(16'(val) * 16'(val));
    startCount++;
    @(negedge clk);
    enb_i = 1'b0;
    dt_i  = WIDTH'($urandom);
  endtask

  // Counts busy cycles from the current falling edge until done_o is seen.
  // Returns at the falling edge where done_o is high. The wait is bounded;
  // running out of budget counts as a failure.
  task automatic waitDone(output int busyCycles);
    bit seen;
    busyCycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (busy_o) busyCycles++;
      @(negedge clk);
    end
    if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int bc;
    int t0;
    int t1;
    int dBefore;
    logic [WIDTH-1:0] v;

    rstn_i = 1'b0;
    enb_i  = 1'b0;
    dt_i   = '0;

    // T1: reset values, then square 0 and check the busy window length.
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_done", 32'(done_o), 32'd0);
    checkOutput("reset_dt_o", 32'(dt_o), 32'd0);
    rstn_i = 1'b1;
    @(negedge clk);
    applyStimulus(8'd0);
    waitDone(bc);
    checkOutput("t1_busy_cycles", 32'(bc), 32'd9);
    checkOutput("t1_busy_low_at_done", 32'(busy_o), 32'd0);

    // T2: a few directed operands. Also check that dt_o holds afterwards.
    @(negedge clk);
    applyStimulus(8'd13);  waitDone(bc);
    @(negedge clk);
    applyStimulus(8'd255); waitDone(bc);
    checkOutput("t2_busy_cycles", 32'(bc), 32'd9);
    repeat (4) @(negedge clk);
    checkOutput("t2_dt_o_hold", 32'(dt_o), 32'd65025);
    applyStimulus(8'd1);   waitDone(bc);

    // T3: hold enb_i high and change dt_i while busy. The second request
    // must be accepted only in the done cycle, and must square 200.
    @(negedge clk);
    dt_i  = 8'd10;
    enb_i = 1'b1;
    scoreboard.push_back(16'd100);
    startCount++;
    @(negedge clk);
    dt_i = 8'd200;
    waitDone(bc);
    checkOutput("t3_busy_cycles", 32'(bc), 32'd9);
    scoreboard.push_back(16'd40000);
    startCount++;
    @(negedge clk);
    enb_i = 1'b0;
    dt_i  = 8'd0;
    waitDone(bc);
    checkOutput("t3_second_busy", 32'(bc), 32'd9);

    // T4: back-to-back 3, 4, 5, with the next start requested in each
    // done cycle. Done pulses must be 10 cycles apart.
    @(negedge clk);
    dt_i  = 8'd3;
    enb_i = 1'b1;
    scoreboard.push_back(16'd9);
    startCount++;
    @(negedge clk);
    waitDone(bc);
    t0 = cycleCount;
    for (int k = 4; k <= 5; k++) begin
      dt_i = WIDTH'(k);
      scoreboard.push_back(16'(k * k));
      startCount++;
      @(negedge clk);
      waitDone(bc);
      t1 = cycleCount;
      checkOutput("t4_done_spacing", 32'(t1 - t0), 32'd10);
      t0 = t1;
    end
    enb_i = 1'b0;

    // T5: reset in the middle of CALC. Outputs must clear immediately and
    // no done_o may appear. A fresh operation must then work normally.
    @(negedge clk);
    applyStimulus(8'd77);
    repeat (3) @(negedge clk);
    rstn_i = 1'b0;
    #1;
    checkOutput("t5_busy_after_rst", 32'(busy_o), 32'd0);
    checkOutput("t5_dt_o_after_rst", 32'(dt_o), 32'd0);
    checkOutput("t5_done_after_rst", 32'(done_o), 32'd0);
    scoreboard.delete();
    startCount--;
    dBefore = doneCount;
    @(negedge clk);
    rstn_i = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("t5_no_done", 32'(doneCount - dBefore), 32'd0);
    applyStimulus(8'd7);
    waitDone(bc);

    // T6: random operands, including both extremes. Some starts go in the
    // done cycle and some come after idle gaps.
    for (int n = 0; n < 1000; n++) begin
      if (n == 0)      v = '0;
      else if (n == 1) v = '1;
      else             v = WIDTH'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      applyStimulus(v);
      waitDone(bc);
    end

    repeat (3) @(negedge clk);
    checkOutput("done_count", 32'(doneCount), 32'(startCount));
    checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
